// File: rtl/sort_stream_ctrl.sv
// Stream-side controller for the dual-port sort RAM: loads one packet into port A,
// hands the RAM to the bubble sorter, then streams the sorted words back out.
module sort_stream_ctrl #(
    parameter int DWIDTH  = 10,
    parameter int ADDR_SZ = 10
) (
    input  logic               clk_i,
    input  logic               srst_i,

    input  logic [DWIDTH-1:0]  snk_data_i,
    input  logic               snk_startofpacket_i,
    input  logic               snk_endofpacket_i,
    input  logic               snk_valid_i,
    output logic               snk_ready_o,

    output logic [DWIDTH-1:0]  src_data_o,
    output logic               src_startofpacket_o,
    output logic               src_endofpacket_o,
    output logic               src_valid_o,
    input  logic               src_ready_i,

    output logic [ADDR_SZ-1:0] ram_address_o,
    output logic [DWIDTH-1:0]  ram_data_o,
    output logic               ram_wren_o,
    input  logic [DWIDTH-1:0]  ram_q_i,

    output logic               sorting_o,
    output logic [ADDR_SZ-1:0] max_counter_o,
    input  logic               done_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DROP   = 3'd2;
    localparam logic [2:0] S_SORT   = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;

    localparam logic [ADDR_SZ-1:0] L_ONE = ADDR_SZ'(1);

    logic [2:0]         r_state;
    logic [ADDR_SZ-1:0] r_count;
    logic [ADDR_SZ-1:0] r_addr;
    logic [DWIDTH-1:0]  r_wdata;
    logic               r_wren;
    logic               r_sorting;

    logic [ADDR_SZ-1:0] r_nxt;
    logic [ADDR_SZ-1:0] r_rd_idx;
    logic               r_pend;
    logic               r_iss_done;
    logic               r_fwd;
    logic [DWIDTH-1:0]  r_fwd_data;

    logic               r_src_valid;
    logic [DWIDTH-1:0]  r_src_data;
    logic               r_src_sop;
    logic               r_src_eop;

    logic               w_snk_ready;
    logic               w_snk_xfer;
    logic               w_src_xfer;
    logic               w_consume;
    logic               w_adv;
    logic               w_issue;
    logic [ADDR_SZ-1:0] w_cnt_inc;
    logic [ADDR_SZ-1:0] w_cnt_dec;
    logic [ADDR_SZ-1:0] w_nxt_inc;
    logic [ADDR_SZ-1:0] w_rd_addr;
    logic [DWIDTH-1:0]  w_rdata;

    assign w_snk_ready = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DROP);
    assign w_snk_xfer  = w_snk_ready && snk_valid_i;
    assign w_src_xfer  = r_src_valid && src_ready_i;
    assign w_consume   = r_pend && (!r_src_valid || src_ready_i);
    assign w_adv       = !r_pend || w_consume;
    assign w_issue     = (r_state == S_UNLOAD) && w_adv && !r_iss_done;
    assign w_cnt_inc   = r_count + L_ONE;
    assign w_cnt_dec   = r_count - L_ONE;
    assign w_nxt_inc   = r_nxt + L_ONE;

    // A stalled read keeps its address on the port so ram_q_i keeps returning the
    // same word; a read that collides with the final write takes the write data.
    assign w_rd_addr   = w_adv ? r_nxt : r_rd_idx;
    assign w_rdata     = r_fwd ? r_fwd_data : ram_q_i;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wren      <= 1'b0;
            r_sorting   <= 1'b0;
            r_nxt       <= '0;
            r_rd_idx    <= '0;
            r_pend      <= 1'b0;
            r_iss_done  <= 1'b0;
            r_fwd       <= 1'b0;
            r_fwd_data  <= '0;
            r_src_valid <= 1'b0;
            r_src_data  <= '0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            if (r_state != S_UNLOAD) begin
                r_nxt       <= '0;
                r_pend      <= 1'b0;
                r_iss_done  <= 1'b0;
                r_fwd       <= 1'b0;
                r_src_valid <= 1'b0;
                r_src_sop   <= 1'b0;
                r_src_eop   <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_snk_xfer && snk_startofpacket_i) begin
                        r_wren  <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= snk_data_i;
                        r_count <= L_ONE;
                        r_state <= snk_endofpacket_i ? S_UNLOAD : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_snk_xfer) begin
                        r_wren  <= 1'b1;
                        r_addr  <= r_count;
                        r_wdata <= snk_data_i;
                        r_count <= w_cnt_inc;
                        if (snk_endofpacket_i) begin
                            r_state <= (w_cnt_inc == L_ONE) ? S_UNLOAD : S_SORT;
                        end else if (w_cnt_inc == '0) begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_DROP: begin
                    if (w_snk_xfer && snk_endofpacket_i) begin
                        r_state <= S_SORT;
                    end
                end
                S_SORT: begin
                    if (!r_sorting) begin
                        r_sorting <= 1'b1;
                    end else if (done_i) begin
                        r_sorting <= 1'b0;
                        r_state   <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (w_issue) begin
                        r_pend     <= 1'b1;
                        r_rd_idx   <= r_nxt;
                        r_nxt      <= w_nxt_inc;
                        r_iss_done <= (w_nxt_inc == r_count);
                        r_fwd      <= r_wren && (r_addr == r_nxt);
                        r_fwd_data <= r_wdata;
                    end else if (w_adv) begin
                        r_pend <= 1'b0;
                    end
                    if (w_consume) begin
                        r_src_valid <= 1'b1;
                        r_src_data  <= w_rdata;
                        r_src_sop   <= (r_rd_idx == '0);
                        r_src_eop   <= (r_rd_idx == w_cnt_dec);
                    end else if (w_src_xfer) begin
                        r_src_valid <= 1'b0;
                    end
                    if (w_src_xfer && r_src_eop) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign snk_ready_o         = !srst_i && w_snk_ready;
    assign src_valid_o         = !srst_i && r_src_valid;
    assign src_data_o          = srst_i ? '0 : r_src_data;
    assign src_startofpacket_o = !srst_i && r_src_sop;
    assign src_endofpacket_o   = !srst_i && r_src_eop;
    assign ram_address_o       = srst_i ? '0 : ((r_state == S_UNLOAD) ? w_rd_addr : r_addr);
    assign ram_data_o          = srst_i ? '0 : r_wdata;
    assign ram_wren_o          = !srst_i && r_wren;
    assign sorting_o           = !srst_i && r_sorting;
    assign max_counter_o       = srst_i ? '0 : r_count;

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl: RAM + sorter fixture, packet-level reference model,
// scoreboard queue popped by an output monitor.
module tb_sort_stream_ctrl;

    localparam int DW  = 10;
    localparam int AW  = 10;
    localparam int CAP = 1 << AW;

    logic          clk;
    logic          srst_i;
    logic [DW-1:0] snk_data_i;
    logic          snk_startofpacket_i;
    logic          snk_endofpacket_i;
    logic          snk_valid_i;
    logic          snk_ready_o;
    logic [DW-1:0] src_data_o;
    logic          src_startofpacket_o;
    logic          src_endofpacket_o;
    logic          src_valid_o;
    logic          src_ready_i;
    logic [AW-1:0] ram_address_o;
    logic [DW-1:0] ram_data_o;
    logic          ram_wren_o;
    logic [DW-1:0] ram_q;
    logic          sorting_o;
    logic [AW-1:0] max_counter_o;
    logic          done_i;

    sort_stream_ctrl #(.DWIDTH(DW), .ADDR_SZ(AW)) dut (
        .clk_i               (clk),
        .srst_i              (srst_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i),
        .ram_address_o       (ram_address_o),
        .ram_data_o          (ram_data_o),
        .ram_wren_o          (ram_wren_o),
        .ram_q_i             (ram_q),
        .sorting_o           (sorting_o),
        .max_counter_o       (max_counter_o),
        .done_i              (done_i)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } item_t;

    item_t         exp_q[$];
    int            n_chk = 0;
    int            n_err = 0;
    bit            mon_en = 1'b1;
    bit            rdy_rand = 1'b0;

    logic [DW-1:0] b_d[$];
    bit            b_s[$];
    bit            b_e[$];
    int            b_gap = 0;

    logic [DW-1:0] mem [0:CAP-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    endtask

    // RAM port A (read-old-data) and a behavioural sorter that owns the RAM while sorting_o is high.
    initial begin
        int            srt_cnt;
        int            srt_delay;
        int            n;
        logic [DW-1:0] sq[$];
        srt_cnt   = 0;
        srt_delay = 3;
        done_i    = 1'b0;
        ram_q     = '0;
        forever begin
            @(posedge clk);
            if (!sorting_o) begin
                if (ram_wren_o) mem[ram_address_o] <= ram_data_o;
                ram_q   <= mem[ram_address_o];
                srt_cnt = 0;
                done_i  <= 1'b0;
            end else if (!done_i) begin
                if (srt_cnt == 0) srt_delay = $urandom_range(3, 12);
                if (srt_cnt >= srt_delay) begin
                    n = (max_counter_o == '0) ? CAP : int'(max_counter_o);
                    sq.delete();
                    for (int i = 0; i < n; i++) sq.push_back(mem[i]);
                    sq.sort();
                    for (int i = 0; i < n; i++) mem[i] <= sq[i];
                    done_i <= 1'b1;
                end else begin
                    srt_cnt++;
                end
            end else begin
                done_i <= 1'b0;
            end
        end
    end

    // Output monitor: drives src_ready_i, pops the scoreboard, checks hold and timing.
    initial begin
        item_t         it;
        bit            prev_v;
        bit            prev_r;
        bit            prev_s;
        bit            prev_e;
        logic [DW-1:0] prev_d;
        bit            prev_sort;
        bit            prev_done;
        bit            armed;
        int            cyc;
        prev_v = 0; prev_r = 0; prev_s = 0; prev_e = 0; prev_d = '0;
        prev_sort = 0; prev_done = 0; armed = 0; cyc = 0;
        src_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            src_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mon_en && !srst_i) begin
                if (prev_v && !prev_r)
                    chk("hold_stable", {src_valid_o, src_startofpacket_o, src_endofpacket_o, src_data_o},
                        {1'b1, prev_s, prev_e, prev_d});
                if (src_valid_o && src_ready_i) begin
                    chk("out_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        it = exp_q.pop_front();
                        chk("out_word", {src_data_o, src_startofpacket_o, src_endofpacket_o}, {it.d, it.s, it.e});
                    end
                end
                if (armed) begin
                    cyc++;
                    if (src_valid_o) begin
                        chk("done_to_valid_cycles", cyc, 3);
                        armed = 0;
                    end else if (cyc > 10) begin
                        chk("done_to_valid_timeout", cyc, 3);
                        armed = 0;
                    end
                end
                if (prev_sort && !sorting_o) begin
                    chk("sorting_held_until_done", prev_done, 1);
                    armed = 1;
                    cyc   = 1;
                end
            end else begin
                armed = 0;
            end
            prev_v    = mon_en && !srst_i && src_valid_o;
            prev_r    = src_ready_i;
            prev_s    = src_startofpacket_o;
            prev_e    = src_endofpacket_o;
            prev_d    = src_data_o;
            prev_sort = sorting_o;
            prev_done = done_i;
        end
    end

    task automatic clear_burst();
        b_d.delete(); b_s.delete(); b_e.delete();
    endtask

    task automatic add(input logic [DW-1:0] d, input bit s, input bit e);
        b_d.push_back(d); b_s.push_back(s); b_e.push_back(e);
    endtask

    // Reference: find the packet in the word list, truncate at capacity, sort it.
    task automatic run_burst(input bit push);
        int            wa[$];
        logic [DW-1:0] pkt[$];
        int            st;
        int            w;
        logic [AW-1:0] cnt;
        item_t         it;
        st = 0;
        for (int i = 0; i < b_d.size(); i++) begin
            wa.push_back(-1);
            if (st == 0 && b_s[i]) begin
                pkt.push_back(b_d[i]);
                wa[i] = 0;
                st = b_e[i] ? 3 : 1;
            end else if (st == 1) begin
                wa[i] = pkt.size();
                pkt.push_back(b_d[i]);
                if (b_e[i]) st = 3;
                else if (pkt.size() == CAP) st = 2;
            end else if (st == 2) begin
                if (b_e[i]) st = 3;
            end
        end
        cnt = AW'(pkt.size() % CAP);
        pkt.sort();
        if (push) begin
            for (int i = 0; i < pkt.size(); i++) begin
                it.d = pkt[i];
                it.s = (i == 0);
                it.e = (i == pkt.size() - 1);
                exp_q.push_back(it);
            end
        end
        for (int i = 0; i < b_d.size(); i++) begin
            repeat ($urandom_range(0, b_gap)) @(negedge clk);
            @(negedge clk);
            snk_valid_i = 1'b1;
            snk_data_i = b_d[i];
            snk_startofpacket_i = b_s[i];
            snk_endofpacket_i = b_e[i];
            w = 0;
            while (!snk_ready_o && w < 5000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 5000) begin
                chk("snk_ready_timeout", w, 0);
                finish_run();
            end
            @(posedge clk);
            #1;
            if (wa[i] >= 0) begin
                chk("wr_en", ram_wren_o, 1);
                chk("wr_addr", ram_address_o, wa[i]);
                chk("wr_data", ram_data_o, b_d[i]);
            end else begin
                chk("no_wr_discard", ram_wren_o, 0);
            end
            snk_valid_i = 1'b0;
        end
        if (pkt.size() > 1) begin
            chk("sort_t1_low", sorting_o, 0);
            @(posedge clk);
            #1;
            chk("sort_t2_high", sorting_o, 1);
            chk("max_counter", max_counter_o, cnt);
        end else if (pkt.size() == 1) begin
            @(posedge clk);
            #1;
            chk("single_valid_t2", src_valid_o, 0);
            @(posedge clk);
            #1;
            chk("single_valid_t3", src_valid_o, 1);
            chk("single_no_sort", sorting_o, 0);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 8000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        srst_i = 1'b1;
        @(negedge clk);
        srst_i = 1'b0;
        #1;
        chk("rst_sorting_low", sorting_o, 0);
        chk("rst_valid_low", src_valid_o, 0);
        chk("rst_ready_high", snk_ready_o, 1);
    endtask

    initial begin
        int w;
        int n;
        srst_i = 1'b1;
        snk_valid_i = 1'b0;
        snk_data_i = '0;
        snk_startofpacket_i = 1'b0;
        snk_endofpacket_i = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_outputs", {snk_ready_o, src_valid_o, src_startofpacket_o, src_endofpacket_o,
                                sorting_o, ram_wren_o}, 0);
            chk("rst_buses", {src_data_o, ram_address_o, ram_data_o, max_counter_o}, 0);
        end
        srst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", snk_ready_o, 1);

        // Directed 8-word packet
        clear_burst();
        add(7, 1, 0); add(3, 0, 0); add(9, 0, 0); add(1, 0, 0);
        add(1, 0, 0); add(0, 0, 0); add(5, 0, 0); add(2, 0, 1);
        run_burst(1);
        drain();

        // Single-word packet
        clear_burst();
        add(42, 1, 1);
        run_burst(1);
        drain();

        // Leading words without sop, duplicated mid-packet sop
        clear_burst();
        add(100, 0, 0); add(200, 0, 1); add(300, 0, 0);
        add(12, 1, 0); add(4, 0, 0); add(9, 1, 0); add(30, 0, 0); add(1, 0, 1);
        b_gap = 2;
        run_burst(1);
        drain();

        // 16 words, random output back-pressure
        rdy_rand = 1'b1;
        clear_burst();
        for (int i = 0; i < 16; i++) add(DW'($urandom), i == 0, i == 15);
        run_burst(1);
        drain();
        rdy_rand = 1'b0;
        b_gap = 0;

        // Full packet without eop, 3 extra words dropped
        clear_burst();
        for (int i = 0; i < CAP; i++) add(DW'($urandom), i == 0, 0);
        add(11, 0, 0); add(22, 0, 0); add(33, 0, 1);
        run_burst(1);
        drain();

        // Reset during SORT
        mon_en = 1'b0;
        clear_burst();
        for (int i = 0; i < 6; i++) add(DW'($urandom), i == 0, i == 5);
        run_burst(0);
        pulse_reset();

        // Reset mid-UNLOAD
        clear_burst();
        for (int i = 0; i < 8; i++) add(DW'($urandom), i == 0, i == 7);
        run_burst(0);
        w = 0;
        while (!src_valid_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("unload_started", src_valid_o, 1);
        repeat (2) @(negedge clk);
        pulse_reset();
        mon_en = 1'b1;

        // 4-word packet after the aborts
        rdy_rand = 1'b1;
        clear_burst();
        add(500, 1, 0); add(3, 0, 0); add(1023, 0, 0); add(77, 0, 1);
        run_burst(1);
        drain();

        // A few random packets
        b_gap = 1;
        for (int p = 0; p < 3; p++) begin
            n = $urandom_range(2, 40);
            clear_burst();
            for (int i = 0; i < n; i++) add(DW'($urandom), i == 0, i == n - 1);
            run_burst(1);
            drain();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        finish_run();
    end

endmodule

// File: doc/sort_stream_ctrl.md
# sort_stream_ctrl

Stream-side controller for the dual-port sort RAM. It takes one packet from an Avalon-ST-style sink, writes it into RAM port A, and runs the bubble sorter through the `sorting_o` / `done_i` / `max_counter_o` handshake. It then reads the sorted words back out of port A onto a source stream. It sits between the top-level stream ports and the RAM; the top-level mux gives the RAM ports to the sorter while `sorting_o` is high and to this block otherwise.

## Interface
- `DWIDTH`, 10, data word width.
- `ADDR_SZ`, 10, RAM address width; packet capacity is 2^ADDR_SZ words.

- `clk_i`  in  1  clock; single clock domain.
- `srst_i`  in  1  reset; synchronous, active-high.
- `snk_data_i`  in  DWIDTH  input word.
- `snk_startofpacket_i`  in  1  first word of packet.
- `snk_endofpacket_i`  in  1  last word of packet.
- `snk_valid_i`  in  1  input word valid.
- `snk_ready_o`  out  1  block accepts input.
- `src_data_o`  out  DWIDTH  sorted output word.
- `src_startofpacket_o`  out  1  first output word.
- `src_endofpacket_o`  out  1  last output word.
- `src_valid_o`  out  1  output word valid.
- `src_ready_i`  in  1  downstream accepts output.
- `ram_address_o`  out  ADDR_SZ  RAM port A address.
- `ram_data_o`  out  DWIDTH  RAM port A write data.
- `ram_wren_o`  out  1  RAM port A write enable.
- `ram_q_i`  in  DWIDTH  RAM port A read data, valid 1 cycle after address.
- `sorting_o`  out  1  sorter run request / RAM ownership to sorter.
- `max_counter_o`  out  ADDR_SZ  word count; 0 means 2^ADDR_SZ.
- `done_i`  in  1  sorter finished (valid while `sorting_o` high).

## Operation
- A transfer occurs on a cycle where valid and ready are both high, on either side.
- States and transitions:
  - IDLE: `snk_ready_o`=1. A transfer with sop → LOAD (word written at address 0). Transfers without sop are discarded. A single-word packet (sop and eop together) → UNLOAD directly.
  - LOAD: `snk_ready_o`=1. Each transfer writes at address = count, then count+1.
    - Mid-packet sop is ignored.
    - Transfer with eop → SORT if count ≥ 2, else UNLOAD.
    - The word that fills capacity (count wraps to 0) closes the packet as if it carried eop; → DROP if that word lacks eop.
  - DROP: `snk_ready_o`=1. Accept and discard words until a transfer with eop, then → SORT.
  - SORT: `snk_ready_o`=0. `sorting_o`=1 and `max_counter_o`=count, both held until `done_i`=1 is sampled. The next cycle `sorting_o`=0 → UNLOAD.
  - UNLOAD: `snk_ready_o`=0. Read addresses 0..N-1 in order and emit each word.
    - `src_startofpacket_o` on word 0; `src_endofpacket_o` on word N-1.
    - After the eop transfer → IDLE.
- Count arithmetic is ADDR_SZ bits and wraps modulo 2^ADDR_SZ; `max_counter_o`=0 encodes a full RAM.
- `ram_wren_o` is high only for LOAD writes. `ram_address_o` and `ram_data_o` are don't-care while `sorting_o`=1.
- Output path: at most one read in flight plus an output register.
  - No word is lost or duplicated under any `src_ready_i` pattern.
  - `src_valid_o`, `src_data_o`, `src_startofpacket_o` and `src_endofpacket_o` stay stable until the transfer completes.

## Timing
- Reset: while `srst_i`=1 every output is 0 and state → IDLE. `snk_ready_o` rises the first cycle after `srst_i` falls.
- Reset mid-operation: in any state, aborts to IDLE the next cycle.
  - `sorting_o` drops the next cycle.
  - Any pending output word is discarded.
  - RAM contents are undefined.
- Write: input transfer at cycle t → `ram_wren_o`/`ram_address_o`/`ram_data_o` registered at t+1.
- Last input transfer at t → `sorting_o` rises at t+2, after the final write.
- `done_i` sampled at t → `sorting_o`=0 at t+1, address 0 presented at t+1, `src_valid_o`=1 at t+3.
- Unload throughput: 1 word/cycle with `src_ready_i` held high.
  - `src_ready_i` low for k cycles stalls the output for exactly k cycles.
- Per-packet input-to-output latency is not bounded by this block; it depends on sorter runtime. No new packet is accepted until UNLOAD completes.

## Test plan
- 8-word packet 7,3,9,1,1,0,5,2 with `src_ready_i`=1 and a behavioural sorter model → `max_counter_o`=8, `sorting_o` held until `done_i`, output 0,1,1,2,3,5,7,9 with sop on 0 and eop on 9.
- Single-word packet 42 → `sorting_o` never asserts; output 42 with sop and eop set, `src_valid_o` rising 2 cycles after UNLOAD entry.
- Full packet of 2^ADDR_SZ words with eop missing on the last, plus 3 extra words then eop → `max_counter_o`=0, the 3 extra words are dropped, 1024 sorted words are output.
- Random `src_ready_i` (50%) during a 16-word unload → exactly 16 transfers in ascending order, data stable while stalled.
- `srst_i` pulsed during SORT and again mid-UNLOAD → `sorting_o`=0 and `src_valid_o`=0 the next cycle, then a following 4-word packet sorts correctly.
- Words without sop while IDLE, then a packet with a duplicated mid-packet sop → leading words discarded, mid sop ignored, correct count and sorted output.
